// File: rtl/vic_prio_sched.sv
// vic_prio_sched: rising-edge capture, priority arbitration and IRQ/ACK/EOI
// handshake for the vectored interrupt controller (31 sources, 4-bit priority).
// Optional macro VIC_NESTING_EN: when defined, a 15-deep active-priority stack
// allows strictly higher-priority sources to preempt; when undefined, only one
// interrupt is in service at a time.
module vic_prio_sched (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [30:0]  i_ext,
  input  logic [123:0] i_reg,
  input  logic         i_en,
  input  logic         i_ack,
  input  logic         i_eoi,
  output logic         o_irq,
  output logic [4:0]   o_irq_addr,
  output logic [3:0]   o_act_prio,
  output logic         o_eoi_err
);

  localparam int unsigned N_SRC  = 31;
  localparam int unsigned PRIO_W = 4;
  localparam int unsigned ADDR_W = 5;
`ifdef VIC_NESTING_EN
  localparam int unsigned STACK_D = 15;
  localparam int unsigned SP_W    = 4;
`endif

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t              state;
  logic [N_SRC-1:0]    ext_q;
  logic [N_SRC-1:0]    pending;
  logic [N_SRC-1:0]    pending_nxt;
  logic [N_SRC-1:0]    ack_clr;
  logic [PRIO_W-1:0]   req_prio;
  logic                ack_fire;
  logic                act_free;
  logic                win_valid;
  logic [ADDR_W-1:0]   win_idx;
  logic [PRIO_W-1:0]   win_prio;

`ifdef VIC_NESTING_EN
  logic [PRIO_W-1:0]   stack [STACK_D];
  logic [SP_W-1:0]     sp;
`endif

  assign ack_fire = (state == S_REQ) && i_ack;

`ifdef VIC_NESTING_EN
  assign act_free = 1'b1;
`else
  assign act_free = (o_act_prio == '0);
`endif

  // Pending update: new edges set, accepted ACK clears; set wins on collision
  always_comb begin
    ack_clr = '0;
    if (ack_fire) ack_clr[o_irq_addr] = 1'b1;
    pending_nxt = (pending & ~ack_clr) | (i_ext & ~ext_q);
  end

  // Winner search: highest priority above the active level, lowest index on ties
  always_comb begin
    logic [PRIO_W-1:0] p;
    win_valid = 1'b0;
    win_idx   = '0;
    win_prio  = '0;
    p         = '0;
    for (int n = 0; n < int'(N_SRC); n++) begin
      p = i_reg[PRIO_W*n +: PRIO_W];
      if (pending[n] && act_free && (p > o_act_prio) && (p > win_prio)) begin
        win_valid = 1'b1;
        win_idx   = ADDR_W'(n);
        win_prio  = p;
      end
    end
  end

  // Handshake FSM, edge capture and active-priority tracking
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      ext_q      <= '0;
      pending    <= '0;
      req_prio   <= '0;
      o_irq      <= 1'b0;
      o_irq_addr <= '0;
      o_act_prio <= '0;
      o_eoi_err  <= 1'b0;
`ifdef VIC_NESTING_EN
      sp <= '0;
      for (int i = 0; i < int'(STACK_D); i++) stack[i] <= '0;
`endif
    end else begin
      ext_q     <= i_ext;
      pending   <= pending_nxt;
      o_eoi_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_en && win_valid) begin
            state      <= S_REQ;
            o_irq      <= 1'b1;
            o_irq_addr <= win_idx;
            req_prio   <= win_prio;
          end
        end
        S_REQ: begin
          // ACK outranks a simultaneous enable drop
          if (i_ack || !i_en) begin
            state <= S_IDLE;
            o_irq <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          o_irq <= 1'b0;
        end
      endcase

`ifdef VIC_NESTING_EN
      // Pop before push: a coincident EOI+ACK replaces the top level in place
      if (i_eoi && ack_fire) begin
        o_act_prio <= req_prio;
        if (sp == '0) o_eoi_err <= 1'b1;
      end else if (i_eoi) begin
        if (sp == '0) begin
          o_act_prio <= '0;
          o_eoi_err  <= 1'b1;
        end else begin
          o_act_prio <= stack[sp - 1'b1];
          sp         <= sp - 1'b1;
        end
      end else if (ack_fire) begin
        if (sp < SP_W'(STACK_D)) begin
          stack[sp] <= o_act_prio;
          sp        <= sp + 1'b1;
        end
        o_act_prio <= req_prio;
      end
`else
      if (ack_fire)   o_act_prio <= req_prio;
      else if (i_eoi) o_act_prio <= '0;
      if (i_eoi && (o_act_prio == '0)) o_eoi_err <= 1'b1;
`endif
    end
  end

endmodule

// File: doc/vic_prio_sched.md
# vic_prio_sched

Priority scheduler for the vectored interrupt controller. Captures rising edges on the 31 external interrupt lines and arbitrates pending sources by their 4-bit priority fields. Presents one vector at a time to the CPU over an IRQ/ACK/EOI handshake, and tracks the active-priority nesting stack so that only strictly higher-priority sources preempt.

## Interface
- No parameters. Source count is fixed at 31, priority width at 4 bits and stack depth at 15.
- i_clk  input  1  system clock; all logic on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_ext  input  31  external interrupt lines, rising-edge sensitive
- i_reg  input  124  priority table; source n priority = i_reg[4n+3:4n]; 0 = source disabled
- i_en  input  1  global enable
- i_ack  input  1  CPU acknowledge pulse (1 cycle)
- i_eoi  input  1  CPU end-of-interrupt pulse (1 cycle)
- o_irq  output  1  interrupt request to CPU
- o_irq_addr  output  5  vector index 0..30 of the presented source
- o_act_prio  output  4  priority of the interrupt currently in service (0 = none)
- o_eoi_err  output  1  1-cycle pulse on EOI with an empty stack

## Operation
- Edge capture: the block registers i_ext into ext_q. Bit n of pending is set on the clock edge where i_ext[n]=1 and ext_q[n]=0.
- pending[n] clears on an accepted ACK when o_irq_addr=n. If a new edge on the same source coincides with that ACK, set wins and pending stays 1.
- Eligibility: pending[n] && prio[n]!=0 && prio[n] > o_act_prio.
- Winner: the eligible source with the highest priority. Ties go to the lowest index.
- FSM IDLE:
  - If i_en=1 and a winner exists, go to REQ.
  - On that transition, latch o_irq_addr = winner and req_prio = prio[winner].
- FSM REQ:
  - o_irq=1. o_irq_addr and req_prio are held stable and there is no re-arbitration.
  - i_ack=1: clear pending[o_irq_addr], push o_act_prio onto the stack, set o_act_prio = req_prio, go to IDLE.
  - i_en=0 (without ACK in the same cycle): go to IDLE, o_irq=0, pending unchanged.
  - ACK takes precedence over i_en=0 in the same cycle.
- EOI, accepted in any state:
  - Pops the stack into o_act_prio.
  - With the stack empty, o_act_prio becomes 0 and o_eoi_err pulses.
- ACK and EOI in the same cycle: EOI pop is applied first, then the ACK push. Net effect: o_act_prio = req_prio and stack depth unchanged.
- i_ack outside REQ is ignored.
- Stack overflow cannot occur, because pushed priorities are strictly increasing over 1..15 (depth 15). The implementation still saturates the pointer.
- Changes to i_reg take effect at the next arbitration. A request already in REQ keeps its latched req_prio.

## Timing
- Reset values: o_irq=0, o_irq_addr=0, o_act_prio=0, o_eoi_err=0. pending, ext_q, stack and stack pointer are all cleared. FSM state is IDLE.
- Reset mid-handshake discards every pending and in-service state.
- Latency, edge to request:
  - i_ext[n] is first sampled high at edge T.
  - pending[n]=1 after T.
  - FSM enters REQ and o_irq=1 after T+1.
- Latency, ACK to next request: ACK at edge T drops o_irq after T. The earliest next o_irq=1 is after T+1, so o_irq shows at least one low cycle between vectors.
- EOI at edge T updates o_act_prio after T. A source unblocked by it can raise o_irq after T+1.
- o_eoi_err is high only for the cycle after the offending EOI.

## Configuration
- Macro: VIC_NESTING_EN.
- Defined: full preemptive nesting as described above, 15-entry stack.
- Undefined:
  - No stack. Eligibility additionally requires o_act_prio==0, so there is no preemption.
  - ACK sets o_act_prio = req_prio.
  - EOI sets o_act_prio = 0. EOI while o_act_prio==0 pulses o_eoi_err.

## Test plan
- Basic request: prio[3]=5, i_ext[3] rises at T, then ACK and EOI -> o_irq=1 after T+1 with o_irq_addr=3; after ACK o_irq=0 and o_act_prio=5; after EOI o_act_prio=0.
- Tie and priority order: prio[7]=prio[2]=9 and prio[20]=4, all three rise in the same cycle, each ACK followed by EOI -> vectors are served in the order 2, 7, 20.
- Nesting (VIC_NESTING_EN): source 4 prio 3 acknowledged, then source 10 prio 12 rises -> o_irq with addr 10; after ACK o_act_prio=12; EOI -> 3; EOI -> 0. Without the macro, addr 10 is presented only after the first EOI.
- Lower priority blocked: o_act_prio=8, source 1 prio 8 rises -> o_irq stays 0 until EOI.
- Enable and disabled source: with prio[5]=0 an edge on source 5 never produces o_irq. An i_en drop during REQ -> o_irq=0 next cycle, and the request reappears once i_en=1.
- Error and reset:
  - EOI with an empty stack -> 1-cycle o_eoi_err.
  - i_rst during REQ -> all outputs 0.
  - Coincident set/clear: a new edge on the ACKed source in the same cycle as the ACK -> pending stays 1 and the source is re-presented.
